rca_share_arbiter: RTL and testbench

Round-robin arbiter and multicycle sequencer that shares one combinational WIDTH-bit ripple carry adder among NREQ requesters.
- Grants one requester at a time and registers its operands.
- Holds the operands stable on the adder for SETTLE_CYCLES clocks so the carry chain resolves inside a multicycle window.
- Captures sum and carry, then returns them with the requester ID over a valid/ready response channel.
- Sits between client blocks and the ripple_adder_64bit instance; the adder is external and connects through the add_* ports.

---
 rtl/rca_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rca_share_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_share_arbiter.sv
// rca_share_arbiter: round-robin front end that time-shares one external
// combinational ripple-carry adder among NREQ requesters. A granted
// request's operands are registered onto the add_* ports and held for
// SETTLE_CYCLES clocks so the slow carry chain resolves as a multicycle
// path. The sum and carry are then captured and returned with the owner ID
// over a valid/ready response channel.
module rca_share_arbiter #(
  parameter int WIDTH         = 64,
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout
);

  // The counter only ever holds 0..SETTLE_CYCLES-1.
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [CNTW-1:0]  cnt_q,        cnt_d;
  logic [IDW-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [WIDTH-1:0] add_a_q,      add_a_d;
  logic [WIDTH-1:0] add_b_q,      add_b_d;
  logic             add_cin_q,    add_cin_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_sum_q,   resp_sum_d;
  logic             resp_cout_q,  resp_cout_d;
  logic [IDW-1:0]   resp_id_q,    resp_id_d;

  logic [NREQ-1:0][WIDTH-1:0] op_a;
  logic [NREQ-1:0][WIDTH-1:0] op_b;
  logic                       win_found;
  logic [IDW-1:0]             win_idx;
  logic                       grant;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign op_a[g] = req_a[g*WIDTH +: WIDTH];
    assign op_b[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: nearest valid requester after ptr, wrapping. Walking
  // k downward lets the closest candidate overwrite farther ones.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   r;
    logic [IDW-1:0] ci;
    int             c;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c  = (int'(ptr) + k) % NREQ;
      ci = IDW'(c);
      if (v[ci]) r = {1'b1, ci};
    end
    return r;
  endfunction

  assign {win_found, win_idx} = rr_pick(req_valid, rr_ptr_q);

  // Grants are only offered from IDLE; a request seen during RESP waits.
  assign grant     = (state_q == S_IDLE) && win_found;
  assign req_ready = (rst_n && grant) ? (NREQ'(1) << win_idx) : '0;

  // Sequencer: accept -> hold operands SETTLE_CYCLES edges -> capture -> respond.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    resp_valid_d = resp_valid_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          add_a_d   = op_a[win_idx];
          add_b_d   = op_b[win_idx];
          add_cin_d = req_cin[win_idx];
          resp_id_d = win_idx;
          rr_ptr_d  = win_idx;
          cnt_d     = '0;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          resp_sum_d   = add_sum;
          resp_cout_d  = add_cout;
          resp_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= IDW'(NREQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Bench for rca_share_arbiter: a default build (SETTLE_CYCLES=3) plus a
// SETTLE_CYCLES=1 build, each with a behavioural adder on its add_* ports.
// Expected results are queued when a grant is seen and popped on response.
module tb_rca_share_arbiter;
  localparam int W   = 64;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default build
  logic [N-1:0]   req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];
  logic           resp_valid, resp_ready, resp_cout, add_cin, add_cout;
  logic [W-1:0]   resp_sum, add_a, add_b, add_sum;
  logic [IDW-1:0] resp_id;

  // SETTLE_CYCLES=1 build
  logic [N-1:0]   s1_req_valid, s1_req_ready, s1_req_cin;
  logic [N*W-1:0] s1_req_a, s1_req_b;
  logic [W-1:0]   s1_op_a [N];
  logic [W-1:0]   s1_op_b [N];
  logic           s1_resp_valid, s1_resp_ready, s1_resp_cout, s1_add_cin, s1_add_cout;
  logic [W-1:0]   s1_resp_sum, s1_add_a, s1_add_b, s1_add_sum;
  logic [IDW-1:0] s1_resp_id;

  always_comb begin
    req_a = '0; req_b = '0; s1_req_a = '0; s1_req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]    = op_a[i];
      req_b[i*W +: W]    = op_b[i];
      s1_req_a[i*W +: W] = s1_op_a[i];
      s1_req_b[i*W +: W] = s1_op_b[i];
    end
  end

  assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign {s1_add_cout, s1_add_sum} = {1'b0, s1_add_a} + {1'b0, s1_add_b} + {{W{1'b0}}, s1_add_cin};

  rca_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW), .SETTLE_CYCLES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .resp_id(resp_id), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout));

  rca_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(s1_req_valid), .req_ready(s1_req_ready),
    .req_a(s1_req_a), .req_b(s1_req_b), .req_cin(s1_req_cin), .resp_valid(s1_resp_valid),
    .resp_ready(s1_resp_ready), .resp_sum(s1_resp_sum), .resp_cout(s1_resp_cout),
    .resp_id(s1_resp_id), .add_a(s1_add_a), .add_b(s1_add_b), .add_cin(s1_add_cin),
    .add_sum(s1_add_sum), .add_cout(s1_add_cout));

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin);
    exp_t e;
    logic [W:0] s;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = IDW'(id);
    e.sum  = s[W-1:0];
    e.cout = s[W];
    return e;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1; resp_ready = 1'b0; req_cin = '0;
    s1_req_valid = '0; s1_resp_ready = 1'b0; s1_req_cin = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rnd64(); op_b[i] = rnd64(); s1_op_a[i] = '0; s1_op_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++;
    if ({resp_valid, resp_sum, resp_cout, resp_id} !== '0) begin
      errors++; $display("FAIL reset_resp: got v=%b sum=%h c=%b id=%0d expected all 0", resp_valid, resp_sum, resp_cout, resp_id);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== '0) begin
      errors++; $display("FAIL reset_add: got a=%h b=%h cin=%b expected all 0", add_a, add_b, add_cin);
    end
    checks++;
    if ({s1_resp_valid, s1_req_ready} !== '0) begin
      errors++; $display("FAIL reset_s1: got v=%b rdy=%b expected 0", s1_resp_valid, s1_req_ready);
    end
    req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op(input string name, input int id, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin,
                                input logic [W-1:0] exp_sum, input logic exp_cout);
    exp_t e;
    int   lat;
    op_a[id] = a; op_b[id] = b; req_cin[id] = cin;
    resp_ready = 1'b1;
    req_valid  = N'(1) << id;
    @(negedge clk);
    checks++;
    if (req_ready !== (N'(1) << id)) begin errors++; $display("FAIL %s_grant: got %b expected %b", name, req_ready, N'(1) << id); end
    e.id = IDW'(id); e.sum = exp_sum; e.cout = exp_cout;
    sbq.push_back(e);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL %s_ready_pulse: got %b expected 0", name, req_ready); end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", name, lat); end
    if (resp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({resp_id, resp_sum, resp_cout} !== {e.id, e.sum, e.cout}) begin
        errors++; $display("FAIL %s_resp: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                           name, resp_id, resp_sum, resp_cout, e.id, e.sum, e.cout);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int   ord [6] = '{0, 1, 2, 3, 0, 1};
    int   g;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rnd64(); op_b[i] = rnd64(); req_cin[i] = 1'($urandom_range(0, 1));
    end
    g = 0;
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        checks++;
        if (g >= 6 || req_ready !== (N'(1) << ord[g])) begin
          errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, (g < 6) ? (N'(1) << ord[g]) : N'(0));
        end else begin
          sbq.push_back(mk_exp(ord[g], op_a[ord[g]], op_b[ord[g]], req_cin[ord[g]]));
        end
        g++;
      end
      if (resp_valid && resp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({resp_id, resp_sum, resp_cout} !== {e.id, e.sum, e.cout}) begin
          errors++; $display("FAIL rr_resp: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                             resp_id, resp_sum, resp_cout, e.id, e.sum, e.cout);
        end
        if (g >= 6 && sbq.size() == 0) break;
      end
      @(posedge clk); #1;
      if (g >= 6) req_valid = '0;
    end
    checks++;
    if (g !== 6 || sbq.size() != 0) begin
      errors++; $display("FAIL rr_complete: got grants=%0d pending=%0d expected 6 and 0", g, sbq.size());
    end
    sbq.delete();
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t           e;
    logic [W-1:0]   s_sum;
    logic           s_cout, stable, rdy_zero;
    logic [IDW-1:0] s_id;
    int             n;
    op_a[2] = rnd64(); op_b[2] = rnd64(); req_cin[2] = 1'b1;
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
    sbq.push_back(mk_exp(2, op_a[2], op_b[2], 1'b1));
    @(posedge clk); #1;
    op_a[0] = rnd64(); op_b[0] = rnd64(); req_cin[0] = 1'b0;
    req_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    s_sum = resp_sum; s_cout = resp_cout; s_id = resp_id;
    stable = resp_valid; rdy_zero = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready !== '0) rdy_zero = 1'b0;
      @(posedge clk); @(negedge clk);
      if (!resp_valid || resp_sum !== s_sum || resp_cout !== s_cout || resp_id !== s_id) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable: got v=%b sum=%h expected held sum=%h", resp_valid, resp_sum, s_sum); end
    checks++;
    if (!rdy_zero) begin errors++; $display("FAIL bp_ready_low: got nonzero req_ready expected 0"); end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_hs_ready: got %b expected 0", req_ready); end
    if (resp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({resp_id, resp_sum, resp_cout} !== {e.id, e.sum, e.cout}) begin
        errors++; $display("FAIL bp_resp: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                           resp_id, resp_sum, resp_cout, e.id, e.sum, e.cout);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume: got %b expected 0001", req_ready); end
    sbq.push_back(mk_exp(0, op_a[0], op_b[0], 1'b0));
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    checks++;
    if (!resp_valid || sbq.size() == 0) begin
      errors++; $display("FAIL bp_second: got resp_valid=%b expected 1", resp_valid);
    end else begin
      e = sbq.pop_front();
      if ({resp_id, resp_sum, resp_cout} !== {e.id, e.sum, e.cout}) begin
        errors++; $display("FAIL bp_second: got id=%0d sum=%h expected id=%0d sum=%h", resp_id, resp_sum, e.id, e.sum);
      end
    end
    sbq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_settle();
    exp_t e;
    logic seen;
    int   n;
    op_a[2] = rnd64(); op_b[2] = rnd64();
    resp_ready = 1'b1;
    req_valid  = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_mid_grant: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_sum, resp_cout, resp_id, add_a, add_b, add_cin} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got v=%b sum=%h a=%h b=%h expected all 0", resp_valid, resp_sum, add_a, add_b);
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid_no_resp: got resp_valid=1 expected 0"); end
    @(posedge clk); #1;
    op_a[0] = rnd64(); op_b[0] = rnd64(); req_cin[0] = 1'b1;
    op_a[3] = rnd64(); op_b[3] = rnd64();
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_first_grant: got %b expected 0001", req_ready); end
    sbq.push_back(mk_exp(0, op_a[0], op_b[0], 1'b1));
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    checks++;
    if (!resp_valid || sbq.size() == 0) begin
      errors++; $display("FAIL rst_mid_after: got resp_valid=%b expected 1", resp_valid);
    end else begin
      e = sbq.pop_front();
      if ({resp_id, resp_sum, resp_cout} !== {e.id, e.sum, e.cout}) begin
        errors++; $display("FAIL rst_mid_after: got id=%0d sum=%h expected id=%0d sum=%h", resp_id, resp_sum, e.id, e.sum);
      end
    end
    sbq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_settle1_back_to_back();
    exp_t e;
    int   ngrant, last_g;
    s1_op_a[1] = 64'd5; s1_op_b[1] = 64'd7; s1_req_cin = '0;
    s1_resp_ready = 1'b1;
    s1_req_valid  = 4'b0010;
    ngrant = 0; last_g = -100;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (s1_req_ready !== '0) begin
        checks++;
        if (s1_req_ready !== 4'b0010 || (ngrant > 0 && cyc - last_g != 3)) begin
          errors++; $display("FAIL s1_grant%0d: got rdy=%b gap=%0d expected 0010 gap=3", ngrant, s1_req_ready, cyc - last_g);
        end
        e.id = 2'd1; e.sum = 64'd12; e.cout = 1'b0;
        sbq.push_back(e);
        last_g = cyc;
        ngrant++;
      end
      if (s1_resp_valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (cyc - last_g != 2 || {s1_resp_id, s1_resp_sum, s1_resp_cout} !== {e.id, e.sum, e.cout}) begin
          errors++; $display("FAIL s1_resp: got id=%0d sum=%0d c=%b at +%0d expected id=%0d sum=%0d c=%b at +2",
                             s1_resp_id, s1_resp_sum, s1_resp_cout, cyc - last_g, e.id, e.sum, e.cout);
        end
        if (ngrant >= 4 && sbq.size() == 0) break;
      end
      @(posedge clk); #1;
      if (ngrant >= 4) s1_req_valid = '0;
    end
    checks++;
    if (ngrant !== 4 || sbq.size() != 0) begin
      errors++; $display("FAIL s1_complete: got grants=%0d pending=%0d expected 4 and 0", ngrant, sbq.size());
    end
    s1_req_valid = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_op("single", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    test_single_op("carry_in", 3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0);
    test_round_robin();
    test_backpressure();
    test_reset_mid_settle();
    test_settle1_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
